sif_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the SIF register/memory backend. It shares one single-port, 1-cycle-read-latency memory between the XA requester (read/write) and the WA requester (write-only). It serialises their strobes into memory cycles and returns a one-cycle acknowledge, plus read data for XA. It sits between the SIF interface ports and the backend array.

---
 rtl/sif_arbiter_if.sv | 47 ++++
 rtl/sif_arbiter.sv | 124 ++++++++++++
 tb/tb_sif_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sif_arbiter_if.sv
// SIF arbiter bundle: XA/WA requester handshakes, backend memory port and
// the sticky protocol-error flag. The slave modport is the arbiter's view;
// the master modport is the view of the requesters plus the backend array.
interface sif_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              xa_rd_s;
    logic              xa_wr_s;
    logic [ADDR_W-1:0] xa_addr;
    logic [DATA_W-1:0] xa_data_wr;
    logic [DATA_W-1:0] xa_data_rd;
    logic              xa_ack;

    logic              wa_wr_s;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data_wr;
    logic              wa_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              sif_err;

    modport slave (
        input  xa_rd_s, xa_wr_s, xa_addr, xa_data_wr,
        output xa_data_rd, xa_ack,
        input  wa_wr_s, wa_addr, wa_data_wr,
        output wa_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output sif_err
    );

    modport master (
        output xa_rd_s, xa_wr_s, xa_addr, xa_data_wr,
        input  xa_data_rd, xa_ack,
        output wa_wr_s, wa_addr, wa_data_wr,
        input  wa_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  sif_err
    );
endinterface

// File: rtl/sif_arbiter.sv
// sif_arbiter: shares one single-port, 1-cycle-read-latency memory between
// the XA (read/write) and WA (write-only) requesters.
// Optional build macro SIF_ARB_FIXED_PRIO_EN: XA always wins simultaneous
// requests; otherwise round-robin with a last-grant pointer that resets to WA.
//
// state   | meaning
// IDLE    | waiting for a strobe; arbitrates and latches the winner
// ACCESS  | memory cycle driven (mem_en=1)
// RD_WAIT | memory returning read data; captured into xa_data_rd
// RESP    | one-cycle ack to the granted side
module sif_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    sif_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RESP} state_t;

    state_t            state;
    logic              gnt_wa;
    logic              lat_we;
`ifndef SIF_ARB_FIXED_PRIO_EN
    logic              last_wa;
`endif

    logic              xa_req;
    logic              wa_req;
    logic              pick_wa;
    logic              nxt_we;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_wdata;

    // Arbitration and selection of the winning request's access fields.
    always_comb begin
        xa_req = bus.xa_rd_s | bus.xa_wr_s;
        wa_req = bus.wa_wr_s;
`ifdef SIF_ARB_FIXED_PRIO_EN
        pick_wa = wa_req & ~xa_req;
`else
        pick_wa = wa_req & (~xa_req | ~last_wa);
`endif
        if (pick_wa) begin
            nxt_we    = 1'b1;
            nxt_addr  = bus.wa_addr;
            nxt_wdata = bus.wa_data_wr;
        end else begin
            // Both XA strobes high is treated as a write.
            nxt_we    = bus.xa_wr_s;
            nxt_addr  = bus.xa_addr;
            nxt_wdata = bus.xa_wr_s ? bus.xa_data_wr : '0;
        end
    end

    // Sequencer FSM with registered memory and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            gnt_wa         <= 1'b0;
            lat_we         <= 1'b0;
`ifndef SIF_ARB_FIXED_PRIO_EN
            last_wa        <= 1'b1;
`endif
            bus.xa_ack     <= 1'b0;
            bus.wa_ack     <= 1'b0;
            bus.xa_data_rd <= '0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.sif_err    <= 1'b0;
        end else begin
            bus.xa_ack    <= 1'b0;
            bus.wa_ack    <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            case (state)
                IDLE: begin
                    if (xa_req || wa_req) begin
                        gnt_wa        <= pick_wa;
                        lat_we        <= nxt_we;
`ifndef SIF_ARB_FIXED_PRIO_EN
                        last_wa       <= pick_wa;
`endif
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= nxt_we;
                        bus.mem_addr  <= nxt_addr;
                        bus.mem_wdata <= nxt_wdata;
                        if (!pick_wa && bus.xa_rd_s && bus.xa_wr_s) begin
                            bus.sif_err <= 1'b1;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_we) begin
                        if (gnt_wa) begin
                            bus.wa_ack <= 1'b1;
                        end else begin
                            bus.xa_ack <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    bus.xa_data_rd <= bus.mem_rdata;
                    bus.xa_ack     <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sif_arbiter.sv
// Bench for sif_arbiter: directed steps followed by random traffic, checked
// against a shadow memory and a grant-order model kept in the bench.
module tb_sif_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sif_arbiter_if bus ();

    sif_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] backend [256];
    logic [15:0] shadow  [256];
    bit          rr_last_wa;
    bit          exp_err;

    // Backend array: single-port, registered read data.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) backend[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= backend[bus.mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which side a fair (or XA-first) arbiter should grant.
    function automatic bit pick_wa(input bit xr, input bit wr);
`ifdef SIF_ARB_FIXED_PRIO_EN
        return wr && !xr;
`else
        if (xr && wr) return !rr_last_wa;
        return wr;
`endif
    endfunction

    // Called in an IDLE cycle with strobes driven; follows one access to the
    // IDLE cycle after its ack, then optionally drops strobes.
    task automatic serve(input bit side_wa, input bit is_wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input bit rel_xa, input bit rel_wa);
        logic [15:0] exp_rd;
        exp_rd = 16'h0;
        @(posedge clk); #1;
        chk("access mem_en", bus.mem_en, 1);
        chk("access mem_we", bus.mem_we, is_wr);
        chk("access mem_addr", bus.mem_addr, addr);
        if (is_wr) chk("access mem_wdata", bus.mem_wdata, wdata);
        chk("access acks", {bus.xa_ack, bus.wa_ack}, 0);
        rr_last_wa = side_wa;
        if (!is_wr) begin
            exp_rd = shadow[addr[7:0]];
            @(posedge clk); #1;
            chk("rdwait mem_en", bus.mem_en, 0);
            chk("rdwait acks", {bus.xa_ack, bus.wa_ack}, 0);
        end else begin
            shadow[addr[7:0]] = wdata;
        end
        @(posedge clk); #1;
        chk("resp xa_ack", bus.xa_ack, !side_wa);
        chk("resp wa_ack", bus.wa_ack, side_wa);
        chk("resp mem_en", bus.mem_en, 0);
        chk("resp mem_addr", bus.mem_addr, 0);
        if (!is_wr) chk("resp xa_data_rd", bus.xa_data_rd, exp_rd);
        chk("sif_err", bus.sif_err, exp_err);
        @(posedge clk); #1;
        chk("idle acks", {bus.xa_ack, bus.wa_ack}, 0);
        chk("idle mem_en", bus.mem_en, 0);
        if (!is_wr) chk("xa_data_rd hold", bus.xa_data_rd, exp_rd);
        if (rel_xa) begin
            bus.xa_rd_s = 1'b0;
            bus.xa_wr_s = 1'b0;
        end
        if (rel_wa) bus.wa_wr_s = 1'b0;
    endtask

    initial begin
        bit          s;
        int          pat;
        bit          xrd, xwr, wwr;
        logic [15:0] xa_a, xa_d, wa_a, wa_d;

        for (int i = 0; i < 256; i++) begin
            backend[i] = 16'h0;
            shadow[i]  = 16'h0;
        end
        rr_last_wa = 1'b1;
        exp_err    = 1'b0;

        // Reset held two cycles with strobes asserted.
        rst_n          = 1'b0;
        bus.xa_rd_s    = 1'b1;
        bus.xa_wr_s    = 1'b0;
        bus.xa_addr    = 16'h0005;
        bus.xa_data_wr = 16'h1234;
        bus.wa_wr_s    = 1'b1;
        bus.wa_addr    = 16'h0006;
        bus.wa_data_wr = 16'h5678;
        @(posedge clk); @(posedge clk); #1;
        chk("rst mem_en", bus.mem_en, 0);
        chk("rst mem_we", bus.mem_we, 0);
        chk("rst mem_addr", bus.mem_addr, 0);
        chk("rst mem_wdata", bus.mem_wdata, 0);
        chk("rst xa_ack", bus.xa_ack, 0);
        chk("rst wa_ack", bus.wa_ack, 0);
        chk("rst xa_data_rd", bus.xa_data_rd, 0);
        chk("rst sif_err", bus.sif_err, 0);
        bus.xa_rd_s = 1'b0;
        bus.wa_wr_s = 1'b0;
        rst_n       = 1'b1;
        @(posedge clk); #1;
        chk("post-rst mem_en", bus.mem_en, 0);

        // WA write then XA read back.
        bus.wa_addr = 16'h0010; bus.wa_data_wr = 16'hBEEF; bus.wa_wr_s = 1'b1;
        serve(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b1);
        bus.xa_addr = 16'h0010; bus.xa_rd_s = 1'b1;
        serve(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0);
        chk("directed read data", bus.xa_data_rd, 16'hBEEF);

        // Simultaneous writes held for three accesses.
        bus.xa_addr = 16'h0001; bus.xa_data_wr = 16'h1111; bus.xa_wr_s = 1'b1;
        bus.wa_addr = 16'h0002; bus.wa_data_wr = 16'h2222; bus.wa_wr_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s = pick_wa(1'b1, 1'b1);
            serve(s, 1'b1, s ? 16'h0002 : 16'h0001, s ? 16'h2222 : 16'h1111, i == 2, i == 2);
        end

        // Both XA strobes: treated as write, sticky error.
        bus.xa_addr = 16'h0003; bus.xa_data_wr = 16'h3333;
        bus.xa_rd_s = 1'b1; bus.xa_wr_s = 1'b1;
        exp_err = 1'b1;
        serve(1'b0, 1'b1, 16'h0003, 16'h3333, 1'b1, 1'b0);

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            pat  = $urandom_range(0, 3);
            xrd  = 1'b0; xwr = 1'b0; wwr = 1'b0;
            xa_a = 16'($urandom_range(0, 31));
            wa_a = 16'($urandom_range(0, 31));
            xa_d = 16'($urandom);
            wa_d = 16'($urandom);
            case (pat)
                0: xrd = 1'b1;
                1: xwr = 1'b1;
                2: wwr = 1'b1;
                default: begin
                    wwr = 1'b1;
                    if ($urandom_range(0, 1) == 0) xrd = 1'b1;
                    else                           xwr = 1'b1;
                end
            endcase
            bus.xa_addr = xa_a; bus.xa_data_wr = xa_d;
            bus.wa_addr = wa_a; bus.wa_data_wr = wa_d;
            bus.xa_rd_s = xrd; bus.xa_wr_s = xwr; bus.wa_wr_s = wwr;
            if ((xrd || xwr) && wwr) begin
                s = pick_wa(1'b1, 1'b1);
                if (s) begin
                    serve(1'b1, 1'b1, wa_a, wa_d, 1'b0, 1'b1);
                    serve(1'b0, xwr, xa_a, xa_d, 1'b1, 1'b0);
                end else begin
                    serve(1'b0, xwr, xa_a, xa_d, 1'b1, 1'b0);
                    serve(1'b1, 1'b1, wa_a, wa_d, 1'b0, 1'b1);
                end
            end else if (wwr) begin
                serve(1'b1, 1'b1, wa_a, wa_d, 1'b0, 1'b1);
            end else begin
                serve(1'b0, xwr, xa_a, xa_d, 1'b1, 1'b0);
            end
        end

        // Reset during RD_WAIT abandons the read.
        bus.wa_addr = 16'h0010; bus.wa_data_wr = 16'hA5A5; bus.wa_wr_s = 1'b1;
        serve(1'b1, 1'b1, 16'h0010, 16'hA5A5, 1'b0, 1'b1);
        bus.xa_addr = 16'h0010; bus.xa_rd_s = 1'b1;
        serve(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
        chk("pre-reset read data", bus.xa_data_rd, 16'hA5A5);
        @(posedge clk); #1;
        chk("abort access mem_en", bus.mem_en, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort xa_ack", bus.xa_ack, 0);
        chk("abort xa_data_rd", bus.xa_data_rd, 0);
        chk("abort mem_en", bus.mem_en, 0);
        chk("abort sif_err", bus.sif_err, 0);
        bus.xa_rd_s = 1'b0;
        rst_n       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post-abort acks", {bus.xa_ack, bus.wa_ack}, 0);
            chk("post-abort mem_en", bus.mem_en, 0);
        end

        // Pointer restored by reset: XA wins the first simultaneous request.
        rr_last_wa = 1'b1;
        exp_err    = 1'b0;
        bus.xa_addr = 16'h0020; bus.xa_data_wr = 16'h0F0F; bus.xa_wr_s = 1'b1;
        bus.wa_addr = 16'h0021; bus.wa_data_wr = 16'hF0F0; bus.wa_wr_s = 1'b1;
        serve(1'b0, 1'b1, 16'h0020, 16'h0F0F, 1'b1, 1'b0);
        serve(1'b1, 1'b1, 16'h0021, 16'hF0F0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
